// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: trains the BPU on every live resolved branch, holds the
// oldest mispredict as a frontend redirect request, then flushes the backend after acceptance.
module branch_redirect_ctrl #(
    parameter int VALEN        = 32,
    parameter int ROB_IDX_W    = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 br_valid_i,
    input  logic [ROB_IDX_W-1:0] br_rob_idx_i,
    input  logic [VALEN-1:0]     br_pc_i,
    input  logic                 br_redirect_i,
    input  logic [VALEN-1:0]     br_target_i,
    input  logic                 br_taken_i,
    input  logic [1:0]           br_type_i,
    output logic                 redirect_valid_o,
    output logic [VALEN-1:0]     redirect_pc_o,
    input  logic                 redirect_ready_i,
    output logic                 flush_o,
    output logic [ROB_IDX_W-1:0] flush_rob_idx_o,
    output logic                 bpu_upd_valid_o,
    output logic [VALEN-1:0]     bpu_upd_pc_o,
    output logic [VALEN-1:0]     bpu_upd_target_o,
    output logic                 bpu_upd_taken_o,
    output logic [1:0]           bpu_upd_type_o
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t               state_r, state_n;
    logic [ROB_IDX_W-1:0] idx_r, idx_n;
    logic [VALEN-1:0]     pc_r, pc_n;
    logic [CNT_W-1:0]     cnt_r, cnt_n;
    logic                 live_s;
    logic                 live_misp_s;

    // ROB age: the MSB is a wrap bit, so a differing MSB inverts the low-bit comparison.
    function automatic logic is_older(input logic [ROB_IDX_W-1:0] a,
                                      input logic [ROB_IDX_W-1:0] b);
        if (a[ROB_IDX_W-1] != b[ROB_IDX_W-1]) begin
            is_older = (a[ROB_IDX_W-2:0] > b[ROB_IDX_W-2:0]);
        end else begin
            is_older = (a[ROB_IDX_W-2:0] < b[ROB_IDX_W-2:0]);
        end
    endfunction

    // A branch is live when no redirect/flush is outstanding or it is strictly older.
    always_comb begin
        live_s      = 1'b0;
        live_misp_s = 1'b0;
        if (br_valid_i) begin
            live_s = (state_r == IDLE) || is_older(br_rob_idx_i, idx_r);
        end else begin
            live_s = 1'b0;
        end
        live_misp_s = live_s && br_redirect_i;
    end

    // Next-state logic; an older mispredict always wins over acceptance or flush progress.
    always_comb begin
        state_n = state_r;
        idx_n   = idx_r;
        pc_n    = pc_r;
        cnt_n   = cnt_r;
        case (state_r)
            IDLE: begin
                if (live_misp_s) begin
                    state_n = REQ;
                    idx_n   = br_rob_idx_i;
                    pc_n    = br_target_i;
                end else begin
                    state_n = IDLE;
                end
            end
            REQ: begin
                if (live_misp_s) begin
                    state_n = REQ;
                    idx_n   = br_rob_idx_i;
                    pc_n    = br_target_i;
                end else if (redirect_ready_i) begin
                    state_n = FLUSH;
                    cnt_n   = CNT_W'(FLUSH_CYCLES - 1);
                end else begin
                    state_n = REQ;
                end
            end
            FLUSH: begin
                if (live_misp_s) begin
                    state_n = REQ;
                    idx_n   = br_rob_idx_i;
                    pc_n    = br_target_i;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= {ROB_IDX_W{1'b0}};
            pc_r    <= {VALEN{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
            pc_r    <= pc_n;
            cnt_r   <= cnt_n;
        end
    end

    // One-cycle BPU training pulse for each live branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            bpu_upd_valid_o  <= 1'b0;
            bpu_upd_pc_o     <= {VALEN{1'b0}};
            bpu_upd_target_o <= {VALEN{1'b0}};
            bpu_upd_taken_o  <= 1'b0;
            bpu_upd_type_o   <= 2'b00;
        end else begin
            bpu_upd_valid_o <= live_s;
            if (live_s) begin
                bpu_upd_pc_o     <= br_pc_i;
                bpu_upd_target_o <= br_target_i;
                bpu_upd_taken_o  <= br_taken_i;
                bpu_upd_type_o   <= br_type_i;
            end
        end
    end

    assign redirect_valid_o = (state_r == REQ);
    assign redirect_pc_o    = (state_r == REQ)   ? pc_r  : {VALEN{1'b0}};
    assign flush_o          = (state_r == FLUSH);
    assign flush_rob_idx_o  = (state_r == FLUSH) ? idx_r : {ROB_IDX_W{1'b0}};

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl; BPU updates are checked through an expectation queue.
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_valid;
    logic [5:0]  br_rob_idx;
    logic [31:0] br_pc;
    logic        br_redirect;
    logic [31:0] br_target;
    logic        br_taken;
    logic [1:0]  br_type;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        flush;
    logic [5:0]  flush_rob_idx;
    logic        bpu_upd_valid;
    logic [31:0] bpu_upd_pc;
    logic [31:0] bpu_upd_target;
    logic        bpu_upd_taken;
    logic [1:0]  bpu_upd_type;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tk;
        logic [1:0]  ty;
    } upd_t;

    upd_t q[$];
    int   errors = 0;
    int   checks = 0;

    branch_redirect_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .br_valid_i       (br_valid),
        .br_rob_idx_i     (br_rob_idx),
        .br_pc_i          (br_pc),
        .br_redirect_i    (br_redirect),
        .br_target_i      (br_target),
        .br_taken_i       (br_taken),
        .br_type_i        (br_type),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .redirect_ready_i (redirect_ready),
        .flush_o          (flush),
        .flush_rob_idx_o  (flush_rob_idx),
        .bpu_upd_valid_o  (bpu_upd_valid),
        .bpu_upd_pc_o     (bpu_upd_pc),
        .bpu_upd_target_o (bpu_upd_target),
        .bpu_upd_taken_o  (bpu_upd_taken),
        .bpu_upd_type_o   (bpu_upd_type)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic br(input logic [5:0] idx, input logic [31:0] pc, input logic redir,
                      input logic [31:0] tgt, input logic tk, input logic [1:0] ty,
                      input logic exp_live);
        upd_t e;
        br_valid    = 1'b1;
        br_rob_idx  = idx;
        br_pc       = pc;
        br_redirect = redir;
        br_target   = tgt;
        br_taken    = tk;
        br_type     = ty;
        if (exp_live) begin
            e.pc = pc; e.tgt = tgt; e.tk = tk; e.ty = ty;
            q.push_back(e);
        end
    endtask

    // Advance one clock, sample #1 after the edge and pop the expected BPU update.
    task automatic tick(input string tag);
        upd_t e;
        @(posedge clk);
        #1;
        br_valid = 1'b0;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, ".upd_valid"}, {31'd0, bpu_upd_valid}, 32'd1);
            chk({tag, ".upd_pc"}, bpu_upd_pc, e.pc);
            chk({tag, ".upd_target"}, bpu_upd_target, e.tgt);
            chk({tag, ".upd_taken"}, {31'd0, bpu_upd_taken}, {31'd0, e.tk});
            chk({tag, ".upd_type"}, {30'd0, bpu_upd_type}, {30'd0, e.ty});
        end else begin
            chk({tag, ".upd_idle"}, {31'd0, bpu_upd_valid}, 32'd0);
        end
    endtask

    task automatic outs(input string tag, input logic rv, input logic [31:0] rpc,
                        input logic fl, input logic [5:0] fidx);
        chk({tag, ".rv"}, {31'd0, redirect_valid}, {31'd0, rv});
        chk({tag, ".rpc"}, redirect_pc, rpc);
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, fl});
        chk({tag, ".fidx"}, {26'd0, flush_rob_idx}, {26'd0, fidx});
    endtask

    initial begin
        rst = 1'b1; br_valid = 1'b0; br_rob_idx = 6'd0; br_pc = 32'd0; br_redirect = 1'b0;
        br_target = 32'd0; br_taken = 1'b0; br_type = 2'd0; redirect_ready = 1'b0;
        tick("rst0"); tick("rst1");
        outs("rst", 1'b0, 32'h0, 1'b0, 6'd0);
        rst = 1'b0;

        // 1: correct branch trains the BPU only
        br(6'd1, 32'h1000, 1'b0, 32'h1004, 1'b1, 2'd3, 1'b1);
        tick("t1");
        outs("t1", 1'b0, 32'h0, 1'b0, 6'd0);
        tick("t1b");

        // 2: mispredict accepted immediately, then a two-cycle flush
        redirect_ready = 1'b1;
        br(6'd5, 32'h1100, 1'b1, 32'h2000, 1'b0, 2'd2, 1'b1);
        tick("t2a"); outs("t2a", 1'b1, 32'h2000, 1'b0, 6'd0);
        tick("t2b"); outs("t2b", 1'b0, 32'h0, 1'b1, 6'd5);
        tick("t2c"); outs("t2c", 1'b0, 32'h0, 1'b1, 6'd5);
        tick("t2d"); outs("t2d", 1'b0, 32'h0, 1'b0, 6'd0);
        redirect_ready = 1'b0;

        // 3: older mispredict replaces, younger and equal are ignored
        br(6'd9, 32'h1200, 1'b1, 32'h2900, 1'b1, 2'd0, 1'b1);
        tick("t3a"); outs("t3a", 1'b1, 32'h2900, 1'b0, 6'd0);
        br(6'd4, 32'h1300, 1'b1, 32'h3000, 1'b1, 2'd1, 1'b1);
        tick("t3b"); outs("t3b", 1'b1, 32'h3000, 1'b0, 6'd0);
        br(6'd7, 32'h1400, 1'b1, 32'h3700, 1'b1, 2'd1, 1'b0);
        tick("t3c"); outs("t3c", 1'b1, 32'h3000, 1'b0, 6'd0);
        br(6'd4, 32'h1500, 1'b1, 32'h4444, 1'b0, 2'd1, 1'b0);
        tick("t3d"); outs("t3d", 1'b1, 32'h3000, 1'b0, 6'd0);
        redirect_ready = 1'b1;
        tick("t3e"); outs("t3e", 1'b0, 32'h0, 1'b1, 6'd4);
        redirect_ready = 1'b0;
        tick("t3f"); tick("t3g");
        outs("t3g", 1'b0, 32'h0, 1'b0, 6'd0);

        // 4: wrap-bit age, then ready coinciding with an older mispredict
        br(6'h02, 32'h1600, 1'b1, 32'h5000, 1'b1, 2'd3, 1'b1);
        tick("t4a"); outs("t4a", 1'b1, 32'h5000, 1'b0, 6'd0);
        br(6'h3E, 32'h1700, 1'b1, 32'h6000, 1'b0, 2'd3, 1'b1);
        tick("t4b"); outs("t4b", 1'b1, 32'h6000, 1'b0, 6'd0);
        redirect_ready = 1'b1;
        br(6'h3D, 32'h1800, 1'b1, 32'h6100, 1'b1, 2'd2, 1'b1);
        tick("t4c"); outs("t4c", 1'b1, 32'h6100, 1'b0, 6'd0);
        tick("t4d"); outs("t4d", 1'b0, 32'h0, 1'b1, 6'h3D);
        redirect_ready = 1'b0;
        tick("t4e"); tick("t4f");
        outs("t4f", 1'b0, 32'h0, 1'b0, 6'd0);

        // 5: flush is aborted by an older mispredict
        redirect_ready = 1'b1;
        br(6'd10, 32'h1900, 1'b1, 32'hA000, 1'b1, 2'd1, 1'b1);
        tick("t5a");
        tick("t5b"); outs("t5b", 1'b0, 32'h0, 1'b1, 6'd10);
        redirect_ready = 1'b0;
        br(6'd12, 32'h1A00, 1'b1, 32'hC000, 1'b1, 2'd1, 1'b0);
        tick("t5c"); outs("t5c", 1'b0, 32'h0, 1'b1, 6'd10);
        br(6'd8, 32'h1B00, 1'b1, 32'h8000, 1'b0, 2'd0, 1'b1);
        tick("t5d"); outs("t5d", 1'b1, 32'h8000, 1'b0, 6'd0);

        // 6: reset in REQ and in FLUSH, then normal operation
        rst = 1'b1;
        tick("t6a"); outs("t6a", 1'b0, 32'h0, 1'b0, 6'd0);
        rst = 1'b0;
        redirect_ready = 1'b1;
        br(6'd3, 32'h1C00, 1'b1, 32'hB000, 1'b1, 2'd2, 1'b1);
        tick("t6b"); outs("t6b", 1'b1, 32'hB000, 1'b0, 6'd0);
        tick("t6c"); outs("t6c", 1'b0, 32'h0, 1'b1, 6'd3);
        rst = 1'b1;
        tick("t6d"); outs("t6d", 1'b0, 32'h0, 1'b0, 6'd0);
        rst = 1'b0;
        redirect_ready = 1'b0;
        br(6'd20, 32'h1D00, 1'b1, 32'hC000, 1'b0, 2'd1, 1'b1);
        tick("t6e"); outs("t6e", 1'b1, 32'hC000, 1'b0, 6'd0);
        redirect_ready = 1'b1;
        tick("t6f"); outs("t6f", 1'b0, 32'h0, 1'b1, 6'd20);
        redirect_ready = 1'b0;
        tick("t6g"); tick("t6h");
        outs("t6h", 1'b0, 32'h0, 1'b0, 6'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
